// File: rtl/top_1_if.sv
// Data bus for the registered population counter:
// the producer drives the word, the counter returns its bit count.
interface top_1_if #(
  parameter int WIDTH = 7,
  parameter int OUT_W = 3
);
  logic [WIDTH-1:0] in;
  logic [OUT_W-1:0] out;

  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );
endinterface

// File: rtl/top_1.sv
// Registered 7-bit population counter built from a 3:2 compressor tree,
// with one output register and synchronous active-low reset.
module top_1 #(
  parameter int WIDTH = 7,
  parameter int OUT_W = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  top_1_if.slave bus
);

  // {carry, sum} of a single-bit full adder
  function automatic logic [1:0] fa(
    input logic a,
    input logic b,
    input logic c
  );
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

  logic [OUT_W-1:0] cnt_d;
  logic [OUT_W-1:0] cnt_q;

  logic s0;
  logic c0;
  logic s1;
  logic c1;
  logic s2;
  logic c2;
  logic s3;
  logic c3;

  // Weight-1 column: two triplets plus in[6] as carry-in.
  // Weight-2 column: the three carries compress to bits [1] and [2].
  always_comb begin
    {c0, s0} = fa(bus.in[0], bus.in[1], bus.in[2]);
    {c1, s1} = fa(bus.in[3], bus.in[4], bus.in[5]);
    {c2, s2} = fa(s0, s1, bus.in[6]);
    {c3, s3} = fa(c0, c1, c2);
    cnt_d    = {c3, s3, s2};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.out = cnt_q;

endmodule

// File: tb/tb_top_1.sv
// Directed bench for the registered population counter.
module tb_top_1;

  logic clk;
  logic rst_n;

  top_1_if #(.WIDTH(7), .OUT_W(3)) bus ();

  top_1 #(.WIDTH(7), .OUT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk;
  int n_fail;
  logic [7:0] hit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string      tag,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive on the falling edge, sample 1ns after the next rising edge
  task automatic step(input logic [6:0] v, input logic r);
    @(negedge clk);
    bus.in = v;
    rst_n  = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref_cnt(input logic [6:0] v);
    logic [2:0] c;
    c = '0;
    for (int k = 0; k < 7; k++) c = c + 3'(v[k]);
    return c;
  endfunction

  logic [6:0] pipe_in [4];
  logic [2:0] pipe_ex [4];

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    hit     = '0;
    rst_n   = 1'b0;
    bus.in  = 7'h7F;

    pipe_in = '{7'h00, 7'h7F, 7'h15, 7'h6A};
    pipe_ex = '{3'd0, 3'd7, 3'd3, 3'd4};

    step(7'h7F, 1'b0);
    check("reset_edge1", bus.out, 3'd0);
    step(7'h7F, 1'b0);
    check("reset_edge2", bus.out, 3'd0);
    step(7'h7F, 1'b1);
    check("reset_release", bus.out, 3'd7);

    for (int i = 0; i < 7; i++) begin
      step(7'(1 << i), 1'b1);
      check($sformatf("walk_bit%0d", i), bus.out, 3'd1);
    end

    for (int i = 0; i < 4; i++) begin
      step(pipe_in[i], 1'b1);
      check($sformatf("pipe%0d", i), bus.out, pipe_ex[i]);
    end

    for (int v = 0; v < 128; v++) begin
      step(7'(v), 1'b1);
      check($sformatf("sweep_%02h", v), bus.out, ref_cnt(7'(v)));
      hit[ref_cnt(7'(v))] = 1'b1;
    end
    check("sweep_cov_lo", hit[2:0], 3'b111);
    check("sweep_cov_hi", {hit[7] & hit[6] & hit[5] & hit[4], 2'b00}, 3'b100);

    step(7'h7F, 1'b1);
    check("mid_stream", bus.out, 3'd7);
    step(7'h55, 1'b0);
    check("mid_reset_wins", bus.out, 3'd0);
    step(7'h7F, 1'b1);
    check("mid_release", bus.out, 3'd7);

    // rst_n pulses low entirely between edges
    @(negedge clk);
    bus.in = 7'h03;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("pulse_hold", bus.out, 3'd7);
    @(posedge clk);
    #1;
    check("pulse_next", bus.out, 3'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
